adc_test: RTL and testbench
===========================

ADC_TEST -- requirements
Module: adc_test

Interface
REQ-001 Parameter ENC_DIV, 32, clk cycles per ENC period; even, >=32.
REQ-002 Parameter SCK_DIV, 8, clk cycles per SPI sck period; even, >=4.
REQ-003 Parameter LED_DIV_LOG2, 24, clk_led toggles every 2^LED_DIV_LOG2 clk.
REQ-004 clk  in  1  system clock; sole clock domain.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 sck/sdo  out  1/1  SPI clock / master data out, shared by both ADCs; sdi  in  1  SPI readback, ignored.
REQ-007 scs1/scs2  out  1/1  active-low SPI chip selects, ADC1/ADC2.
REQ-008 ENC_p/ENC_n  out  1/1  differential ADC encode clock.
REQ-009 DCOk_p/_n, FRk_p/_n (k=1,2)  in  1  ADC bit clock and frame.
REQ-010 Dk0_p/_n, Dk1_p/_n  in  2  ADC k channel 0/1 lanes [1:0].
REQ-011 ADC1_out/ADC2_out  out  1  ADC monitor bit; clk_led/rst_led  out  1  status LEDs.
REQ-012 Differential inputs are resolved using _p only; _n inputs are unused.

Function
REQ-013 ENC_p is a clk-divided square wave, ENC_DIV/2 clk high, ENC_DIV/2 low; ENC_n = ~ENC_p.
REQ-014 Every DCO, FR and D _p input passes a 2-flop synchronizer into clk before use.
REQ-015 A bit-time occurs on each clk where the synchronized DCO differs from its previous value (DDR, both edges).
REQ-016 Per channel, each bit-time shifts lane[1] and lane[0] into a 16-bit register, MSB first; lane[1] carries bits 15,13..1, lane[0] bits 14,12..0.
REQ-017 A synchronized FR rising edge coinciding with a bit-time marks the first bit-time (bits 15,14) of a frame; after 8 bit-times the 16-bit word is latched into that channel's result register.
REQ-018 A new FR rising edge before 8 bit-times restarts the bit count, discarding the partial word.
REQ-019 ADCk_out is registered bit 15 of ADC k channel 0 result register.
REQ-020 After reset release, SPI master writes CFG_TABLE entries in order to ADC1 (scs1 low), then the same table to ADC2 (scs2 low).
REQ-021 SPI frame: 16 bits, MSB first: R/W=0, 7-bit address, 8-bit data; mode 0, sck idle low, sdo changes SCK_DIV/2 clk before sck rise.
REQ-022 scs falls SCK_DIV/2 clk before first sck rise, rises SCK_DIV/2 clk after last sck fall; >=SCK_DIV clk high between frames.
REQ-023 After the last ADC2 frame, SPI is idle forever: sck=0, sdo=0, scs1=scs2=1; cfg_done=1.
REQ-024 clk_led toggles every 2^LED_DIV_LOG2 clk; rst_led = ~cfg_done.

Reset
REQ-025 rst_n low: ENC_p=0, ENC_n=1, sck=0, sdo=0, scs1=scs2=1, ADCk_out=0, all shift/result registers 0, clk_led=0, rst_led=1, cfg_done=0.
REQ-026 Reset asserted mid-SPI-frame aborts it; release restarts the sequence from entry 0 of ADC1.

Configuration
REQ-027 Macro ADC_TEST_ADC2_EN defined: ADC2 receiver and ADC2 SPI pass present.
REQ-028 Without ADC_TEST_ADC2_EN: ADC2_out=0, scs2=1 permanently, cfg_done asserts after the ADC1 pass.

Structure
REQ-029 Package adc_test_pkg holds CFG_TABLE (3 entries: {0x00,0x80} reset, {0x02,0x00}, {0x03,0x00}), its length, frame width 16, lane count 2.
REQ-030 One sub-module adc_deser (synchronizers, DCO edge detect, two channel deserializers) instantiated once per ADC.

Verification
REQ-031 Reset release, clk 100 MHz -> ENC_p period 320 ns; first sck rise on scs1 low shifts 0x0080; 3 frames ADC1 then 3 ADC2; rst_led falls after frame 6.
REQ-032 ADC1 driven with DCO half-period 4 clk, FR aligned, lanes encoding ch0=0x8001, ch1=0x1234 -> result registers 0x8001/0x1234; ADC1_out=1.
REQ-033 Next frame ch0=0x7FFF -> ADC1_out falls within 4 clk of the latch.
REQ-034 FR re-asserted after 5 bit-times -> partial word discarded; following complete frame 0xA5A5 latched correctly.
REQ-035 rst_n pulsed low during ADC1 frame 2 -> all outputs at reset values; sequence restarts with 0x0080 to ADC1.
REQ-036 Build without ADC_TEST_ADC2_EN -> scs2 never falls, rst_led falls after frame 3.

Source files
------------

// File: rtl/adc_test_pkg.sv
// Shared types and constants for the ADC test block: SPI configuration table,
// frame/lane geometry, SPI sequencer states and receiver result payload.
package adc_test_pkg;

    localparam int unsigned FRAME_W        = 16;
    localparam int unsigned LANE_N         = 2;
    localparam int unsigned BITS_PER_FRAME = FRAME_W / LANE_N;
    localparam int unsigned CFG_LEN        = 3;
    localparam int unsigned CFG_IDX_W      = 2;

    // Entry 0 is the soft reset write and goes out first.
    localparam logic [CFG_LEN-1:0][FRAME_W-1:0] CFG_TABLE = {
        16'h0300,
        16'h0200,
        16'h0080
    };

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } spi_frame_t;

    typedef struct packed {
        logic [FRAME_W-1:0] ch1;
        logic [FRAME_W-1:0] ch0;
    } adc_res_t;

    typedef enum logic [2:0] {
        SPI_GAP  = 3'd0,
        SPI_LOW  = 3'd1,
        SPI_HIGH = 3'd2,
        SPI_HOLD = 3'd3,
        SPI_DONE = 3'd4
    } spi_state_e;

    function automatic spi_frame_t cfg_entry(input logic [CFG_IDX_W-1:0] idx);
        return (idx < CFG_IDX_W'(CFG_LEN)) ? spi_frame_t'(CFG_TABLE[idx])
                                           : spi_frame_t'(FRAME_W'(0));
    endfunction

endpackage

// File: rtl/adc_test_if.sv
// SPI configuration bus shared by both ADCs, with per-ADC chip selects.
interface adc_test_if;

    logic sck;
    logic sdo;
    logic sdi;
    logic scs1;
    logic scs2;

    modport master (output sck, output sdo, output scs1, output scs2, input sdi);
    modport slave  (input sck, input sdo, input scs1, input scs2, output sdi);

endinterface

// File: rtl/adc_deser.sv
// One ADC receiver: synchronizes DCO/FR/lanes into clk, detects DDR bit-times
// and assembles the two 16-bit channel words framed by FR.
module adc_deser
    import adc_test_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dco,
    input  logic              fr,
    input  logic [LANE_N-1:0] d0,
    input  logic [LANE_N-1:0] d1,
    output adc_res_t          result
);

    localparam int unsigned CNT_W = $clog2(BITS_PER_FRAME + 1);

    logic [1:0]         dco_sync;
    logic [1:0]         fr_sync;
    logic [LANE_N-1:0]  d0_meta, d0_sync;
    logic [LANE_N-1:0]  d1_meta, d1_sync;
    logic               dco_prev;
    logic               fr_prev;
    logic [FRAME_W-1:0] sh0, sh1;
    logic [CNT_W-1:0]   bit_cnt;

    logic               bit_time_c;
    logic               frame_start_c;
    logic [FRAME_W-1:0] sh0_c, sh1_c;

    // Lane[1] lands one position above lane[0], so each bit-time appends two bits MSB first.
    assign bit_time_c    = dco_sync[1] ^ dco_prev;
    assign frame_start_c = bit_time_c & fr_sync[1] & ~fr_prev;
    assign sh0_c         = {sh0[FRAME_W-LANE_N-1:0], d0_sync};
    assign sh1_c         = {sh1[FRAME_W-LANE_N-1:0], d1_sync};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dco_sync <= '0;
            fr_sync  <= '0;
            d0_meta  <= '0;
            d0_sync  <= '0;
            d1_meta  <= '0;
            d1_sync  <= '0;
            dco_prev <= 1'b0;
            fr_prev  <= 1'b0;
            sh0      <= '0;
            sh1      <= '0;
            bit_cnt  <= '0;
            result   <= '0;
        end else begin
            dco_sync <= {dco_sync[0], dco};
            fr_sync  <= {fr_sync[0], fr};
            d0_meta  <= d0;
            d0_sync  <= d0_meta;
            d1_meta  <= d1;
            d1_sync  <= d1_meta;
            dco_prev <= dco_sync[1];
            fr_prev  <= fr_sync[1];
            if (bit_time_c) begin
                sh0 <= sh0_c;
                sh1 <= sh1_c;
                // bit_cnt==0 means no frame in progress; an FR edge always restarts.
                if (frame_start_c) begin
                    bit_cnt <= CNT_W'(1);
                end else if (bit_cnt == CNT_W'(BITS_PER_FRAME - 1)) begin
                    result  <= '{ch1: sh1_c, ch0: sh0_c};
                    bit_cnt <= '0;
                end else if (bit_cnt != '0) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/adc_test.sv
// ADC test top: ENC clock generation, SPI configuration of the ADCs, LVDS
// receivers and status LEDs. Define ADC_TEST_ADC2_EN to include the second ADC.
module adc_test
    import adc_test_pkg::*;
#(
    parameter int unsigned ENC_DIV      = 32,
    parameter int unsigned SCK_DIV      = 8,
    parameter int unsigned LED_DIV_LOG2 = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    adc_test_if.master        spi,
    output logic              ENC_p,
    output logic              ENC_n,
    input  logic              DCO1_p,
    input  logic              DCO1_n,
    input  logic              FR1_p,
    input  logic              FR1_n,
    input  logic [LANE_N-1:0] D10_p,
    input  logic [LANE_N-1:0] D10_n,
    input  logic [LANE_N-1:0] D11_p,
    input  logic [LANE_N-1:0] D11_n,
    input  logic              DCO2_p,
    input  logic              DCO2_n,
    input  logic              FR2_p,
    input  logic              FR2_n,
    input  logic [LANE_N-1:0] D20_p,
    input  logic [LANE_N-1:0] D20_n,
    input  logic [LANE_N-1:0] D21_p,
    input  logic [LANE_N-1:0] D21_n,
    output logic              ADC1_out,
    output logic              ADC2_out,
    output logic              clk_led,
    output logic              rst_led
);

    localparam int unsigned ENC_HALF = ENC_DIV / 2;
    localparam int unsigned ENC_W    = $clog2(ENC_HALF);
    localparam int unsigned SCK_HALF = SCK_DIV / 2;
    localparam int unsigned TMR_W    = $clog2(SCK_DIV);
    localparam int unsigned BIT_W    = $clog2(FRAME_W);
`ifdef ADC_TEST_ADC2_EN
    localparam logic LAST_DEV = 1'b1;
`else
    localparam logic LAST_DEV = 1'b0;
`endif

    logic [ENC_W-1:0]        enc_cnt;
    logic [LED_DIV_LOG2-1:0] led_cnt;

    spi_state_e             state, state_nx;
    logic [TMR_W-1:0]       tmr, tmr_nx;
    logic [BIT_W-1:0]       bit_idx, bit_nx;
    logic [FRAME_W-1:0]     shreg, shreg_nx;
    logic [CFG_IDX_W-1:0]   entry, entry_nx;
    logic                   dev, dev_nx;
    logic                   sck_q, sck_nx;
    logic                   sdo_q, sdo_nx;
    logic                   scs1_q, scs1_nx;
    logic                   scs2_q, scs2_nx;
    logic                   cfg_done, done_nx;
    logic [FRAME_W-1:0]     frame_c;

    adc_res_t res1;
    adc_res_t res2;

    assign spi.sck  = sck_q;
    assign spi.sdo  = sdo_q;
    assign spi.scs1 = scs1_q;
    assign spi.scs2 = scs2_q;
    assign frame_c  = cfg_entry(entry);

    // Encode clock: symmetric divide of clk, complementary pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_cnt <= '0;
            ENC_p   <= 1'b0;
            ENC_n   <= 1'b1;
        end else if (enc_cnt == ENC_W'(ENC_HALF - 1)) begin
            enc_cnt <= '0;
            ENC_p   <= ~ENC_p;
            ENC_n   <= ~ENC_n;
        end else begin
            enc_cnt <= enc_cnt + ENC_W'(1);
        end
    end

    // SPI sequencer next-state: walks the table for ADC1, then ADC2, then parks.
    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        bit_nx   = bit_idx;
        shreg_nx = shreg;
        entry_nx = entry;
        dev_nx   = dev;
        sck_nx   = sck_q;
        sdo_nx   = sdo_q;
        scs1_nx  = scs1_q;
        scs2_nx  = scs2_q;
        done_nx  = cfg_done;
        case (state)
            SPI_GAP: begin
                if (tmr == '0) begin
                    state_nx = SPI_LOW;
                    tmr_nx   = TMR_W'(SCK_HALF - 1);
                    bit_nx   = BIT_W'(FRAME_W - 1);
                    shreg_nx = frame_c;
                    sdo_nx   = frame_c[FRAME_W-1];
                    scs1_nx  = dev;
                    scs2_nx  = ~dev;
                end else begin
                    tmr_nx = tmr - TMR_W'(1);
                end
            end
            SPI_LOW: begin
                if (tmr == '0) begin
                    state_nx = SPI_HIGH;
                    tmr_nx   = TMR_W'(SCK_HALF - 1);
                    sck_nx   = 1'b1;
                end else begin
                    tmr_nx = tmr - TMR_W'(1);
                end
            end
            SPI_HIGH: begin
                if (tmr == '0) begin
                    tmr_nx = TMR_W'(SCK_HALF - 1);
                    sck_nx = 1'b0;
                    if (bit_idx == '0) begin
                        state_nx = SPI_HOLD;
                        sdo_nx   = 1'b0;
                    end else begin
                        state_nx = SPI_LOW;
                        bit_nx   = bit_idx - BIT_W'(1);
                        shreg_nx = {shreg[FRAME_W-2:0], 1'b0};
                        sdo_nx   = shreg[FRAME_W-2];
                    end
                end else begin
                    tmr_nx = tmr - TMR_W'(1);
                end
            end
            SPI_HOLD: begin
                if (tmr == '0) begin
                    scs1_nx  = 1'b1;
                    scs2_nx  = 1'b1;
                    state_nx = SPI_GAP;
                    tmr_nx   = TMR_W'(SCK_DIV - 1);
                    if (entry == CFG_IDX_W'(CFG_LEN - 1)) begin
                        entry_nx = '0;
                        if (dev == LAST_DEV) begin
                            state_nx = SPI_DONE;
                            done_nx  = 1'b1;
                        end else begin
                            dev_nx = 1'b1;
                        end
                    end else begin
                        entry_nx = entry + CFG_IDX_W'(1);
                    end
                end else begin
                    tmr_nx = tmr - TMR_W'(1);
                end
            end
            SPI_DONE: begin
                sck_nx  = 1'b0;
                sdo_nx  = 1'b0;
                scs1_nx = 1'b1;
                scs2_nx = 1'b1;
            end
            default: begin
                state_nx = SPI_GAP;
                tmr_nx   = TMR_W'(SCK_DIV - 1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SPI_GAP;
            tmr      <= TMR_W'(SCK_DIV - 1);
            bit_idx  <= '0;
            shreg    <= '0;
            entry    <= '0;
            dev      <= 1'b0;
            sck_q    <= 1'b0;
            sdo_q    <= 1'b0;
            scs1_q   <= 1'b1;
            scs2_q   <= 1'b1;
            cfg_done <= 1'b0;
            rst_led  <= 1'b1;
        end else begin
            state    <= state_nx;
            tmr      <= tmr_nx;
            bit_idx  <= bit_nx;
            shreg    <= shreg_nx;
            entry    <= entry_nx;
            dev      <= dev_nx;
            sck_q    <= sck_nx;
            sdo_q    <= sdo_nx;
            scs1_q   <= scs1_nx;
            scs2_q   <= scs2_nx;
            cfg_done <= done_nx;
            rst_led  <= ~done_nx;
        end
    end

    // Heartbeat LED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_cnt <= '0;
            clk_led <= 1'b0;
        end else begin
            led_cnt <= led_cnt + LED_DIV_LOG2'(1);
            if (led_cnt == '1) begin
                clk_led <= ~clk_led;
            end
        end
    end

    adc_deser u_deser1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .dco    (DCO1_p),
        .fr     (FR1_p),
        .d0     (D10_p),
        .d1     (D11_p),
        .result (res1)
    );

`ifdef ADC_TEST_ADC2_EN
    adc_deser u_deser2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .dco    (DCO2_p),
        .fr     (FR2_p),
        .d0     (D20_p),
        .d1     (D21_p),
        .result (res2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ADC1_out <= 1'b0;
            ADC2_out <= 1'b0;
        end else begin
            ADC1_out <= res1.ch0[FRAME_W-1];
            ADC2_out <= res2.ch0[FRAME_W-1];
        end
    end

    logic unused_pins;
    assign unused_pins = ^{DCO1_n, FR1_n, D10_n, D11_n, DCO2_n, FR2_n, D20_n, D21_n,
                           spi.sdi, res1, res2};
`else
    assign res2     = '0;
    assign ADC2_out = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ADC1_out <= 1'b0;
        end else begin
            ADC1_out <= res1.ch0[FRAME_W-1];
        end
    end

    logic unused_pins;
    assign unused_pins = ^{DCO1_n, FR1_n, D10_n, D11_n, DCO2_p, DCO2_n, FR2_p, FR2_n,
                           D20_p, D20_n, D21_p, D21_n, spi.sdi, res1, res2};
`endif

endmodule

// File: tb/tb_adc_test.sv
// Directed self-checking bench for adc_test: reset values, SPI configuration
// sequence, ENC/LED timing, ADC frame reception and mid-frame reset.
module tb_adc_test;

`ifdef ADC_TEST_ADC2_EN
    localparam int  NFR     = 6;
    localparam bit  ADC2_EN = 1'b1;
`else
    localparam int  NFR     = 3;
    localparam bit  ADC2_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ENC_p, ENC_n, ADC1_out, ADC2_out, clk_led, rst_led;
    logic DCO1_p = 1'b0, FR1_p = 1'b0, DCO2_p = 1'b0, FR2_p = 1'b0;
    logic DCO1_n, FR1_n, DCO2_n, FR2_n;
    logic [1:0] D10_p = '0, D11_p = '0, D20_p = '0, D21_p = '0;
    logic [1:0] D10_n, D11_n, D20_n, D21_n;
    logic scs2_seen = 1'b0;

    int tests = 0;
    int fails = 0;

    adc_test_if spi ();

    assign spi.sdi = 1'b0;
    assign DCO1_n = ~DCO1_p;
    assign FR1_n  = ~FR1_p;
    assign D10_n  = ~D10_p;
    assign D11_n  = ~D11_p;
    assign DCO2_n = ~DCO2_p;
    assign FR2_n  = ~FR2_p;
    assign D20_n  = ~D20_p;
    assign D21_n  = ~D21_p;

    adc_test #(.ENC_DIV(32), .SCK_DIV(8), .LED_DIV_LOG2(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi      (spi.master),
        .ENC_p    (ENC_p),
        .ENC_n    (ENC_n),
        .DCO1_p   (DCO1_p),
        .DCO1_n   (DCO1_n),
        .FR1_p    (FR1_p),
        .FR1_n    (FR1_n),
        .D10_p    (D10_p),
        .D10_n    (D10_n),
        .D11_p    (D11_p),
        .D11_n    (D11_n),
        .DCO2_p   (DCO2_p),
        .DCO2_n   (DCO2_n),
        .FR2_p    (FR2_p),
        .FR2_n    (FR2_n),
        .D20_p    (D20_p),
        .D20_n    (D20_n),
        .D21_p    (D21_p),
        .D21_n    (D21_n),
        .ADC1_out (ADC1_out),
        .ADC2_out (ADC2_out),
        .clk_led  (clk_led),
        .rst_led  (rst_led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && spi.scs2 === 1'b0) scs2_seen <= 1'b1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for a chip select to fall and collects 16 bits on sck rising edges.
    task automatic spi_capture(output int dev, output logic [15:0] word, output int setup);
        int  n;
        logic prev;
        dev = 0; word = '0; setup = 0; n = 0;
        while (spi.scs1 === 1'b1 && spi.scs2 === 1'b1 && n < 1000) begin
            step(1); n++;
        end
        if (n >= 1000) return;
        dev = (spi.scs1 === 1'b0) ? 1 : 2;
        for (int b = 0; b < 16; b++) begin
            n = 0;
            do begin
                prev = spi.sck;
                step(1);
                n++;
            end while (!(prev === 1'b0 && spi.sck === 1'b1) && n < 100);
            if (b == 0) setup = n;
            word = {word[14:0], spi.sdo};
        end
        n = 0;
        while ((spi.scs1 === 1'b0 || spi.scs2 === 1'b0) && n < 100) begin
            step(1); n++;
        end
    endtask

    // Drives one ADC frame: one DDR bit-time per 4 clk, FR high for the first half.
    task automatic send_frame(input int sel, input logic [15:0] c0, input logic [15:0] c1,
                              input int nbits);
        logic [1:0] l0, l1;
        for (int i = 0; i < nbits; i++) begin
            l0 = {c0[15-2*i], c0[14-2*i]};
            l1 = {c1[15-2*i], c1[14-2*i]};
            if (sel == 1) begin D10_p = l0; D11_p = l1; end
            else          begin D20_p = l0; D21_p = l1; end
            step(2);
            if (sel == 1) begin DCO1_p = ~DCO1_p; FR1_p = (i < 4); end
            else          begin DCO2_p = ~DCO2_p; FR2_p = (i < 4); end
            step(2);
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_enc_p"},   32'(ENC_p),    32'h0);
        check({pfx, "_enc_n"},   32'(ENC_n),    32'h1);
        check({pfx, "_sck"},     32'(spi.sck),  32'h0);
        check({pfx, "_sdo"},     32'(spi.sdo),  32'h0);
        check({pfx, "_scs1"},    32'(spi.scs1), 32'h1);
        check({pfx, "_scs2"},    32'(spi.scs2), 32'h1);
        check({pfx, "_adc1"},    32'(ADC1_out), 32'h0);
        check({pfx, "_adc2"},    32'(ADC2_out), 32'h0);
        check({pfx, "_clk_led"}, 32'(clk_led),  32'h0);
        check({pfx, "_rst_led"}, 32'(rst_led),  32'h1);
        check({pfx, "_res1"},    32'(dut.u_deser1.result), 32'h0);
    endtask

    initial begin
        int         dev, setup, n, hi, lo;
        logic [15:0] word;
        logic [15:0] exp_words [3];
        exp_words[0] = 16'h0080;
        exp_words[1] = 16'h0200;
        exp_words[2] = 16'h0300;

        // Reset state
        rst_n = 1'b0;
        step(3);
        check_reset_values("rst");
        rst_n = 1'b1;

        // Configuration sequence
        for (int f = 0; f < NFR; f++) begin
            if (f == NFR - 1) check("rst_led_before_last", 32'(rst_led), 32'h1);
            spi_capture(dev, word, setup);
            check($sformatf("cfg%0d_dev", f),  32'(dev),  32'((f < 3) ? 1 : 2));
            check($sformatf("cfg%0d_word", f), 32'(word), 32'(exp_words[f % 3]));
            if (f == 0) check("scs_setup_clks", 32'(setup), 32'd4);
        end
        step(2);
        check("rst_led_after_cfg", 32'(rst_led), 32'h0);
        step(40);
        check("idle_sck",  32'(spi.sck),  32'h0);
        check("idle_sdo",  32'(spi.sdo),  32'h0);
        check("idle_scs1", 32'(spi.scs1), 32'h1);
        check("idle_scs2", 32'(spi.scs2), 32'h1);
        check("scs2_used", 32'(scs2_seen), 32'(ADC2_EN));

        // ENC timing: 16 clk high, 16 clk low
        n = 0; while (ENC_p !== 1'b0 && n < 100) begin step(1); n++; end
        n = 0; while (ENC_p !== 1'b1 && n < 100) begin step(1); n++; end
        check("enc_n_compl", 32'(ENC_n), 32'h0);
        hi = 0; while (ENC_p === 1'b1 && hi < 100) begin step(1); hi++; end
        lo = 0; while (ENC_p === 1'b0 && lo < 100) begin step(1); lo++; end
        check("enc_high_clks", 32'(hi), 32'd16);
        check("enc_low_clks",  32'(lo), 32'd16);

        // Heartbeat LED toggles every 16 clk
        n = 0; while (clk_led !== 1'b0 && n < 100) begin step(1); n++; end
        n = 0; while (clk_led !== 1'b1 && n < 100) begin step(1); n++; end
        hi = 0; while (clk_led === 1'b1 && hi < 100) begin step(1); hi++; end
        check("led_half_period", 32'(hi), 32'd16);

        // ADC1 reception
        send_frame(1, 16'h8001, 16'h1234, 8);
        step(4);
        check("adc1_ch0_8001", 32'(dut.u_deser1.result.ch0), 32'h8001);
        check("adc1_ch1_1234", 32'(dut.u_deser1.result.ch1), 32'h1234);
        check("adc1_out_hi",   32'(ADC1_out), 32'h1);

        send_frame(1, 16'h7FFF, 16'hC3C3, 8);
        step(3);
        check("adc1_out_fall", 32'(ADC1_out), 32'h0);
        check("adc1_ch0_7fff", 32'(dut.u_deser1.result.ch0), 32'h7FFF);

        send_frame(1, 16'h1111, 16'h2222, 5);
        step(4);
        check("partial_discard", 32'(dut.u_deser1.result.ch0), 32'h7FFF);
        send_frame(1, 16'hA5A5, 16'h5A5A, 8);
        step(4);
        check("adc1_ch0_a5a5", 32'(dut.u_deser1.result.ch0), 32'hA5A5);
        check("adc1_ch1_5a5a", 32'(dut.u_deser1.result.ch1), 32'h5A5A);
        check("adc1_out_a5",   32'(ADC1_out), 32'h1);

        // ADC2 reception (absent builds keep ADC2_out low)
        send_frame(2, 16'h8000, 16'h0001, 8);
        step(4);
        check("adc2_out", 32'(ADC2_out), 32'(ADC2_EN));

        // Restart, then reset in the middle of ADC1 frame 2
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        spi_capture(dev, word, setup);
        check("restart_dev",  32'(dev),  32'd1);
        check("restart_word", 32'(word), 32'h0080);
        n = 0; while (spi.scs1 !== 1'b0 && n < 200) begin step(1); n++; end
        step(30);
        check("mid_frame2_scs1", 32'(spi.scs1), 32'h0);
        rst_n = 1'b0;
        #2;
        check_reset_values("midrst");
        step(3);
        rst_n = 1'b1;
        spi_capture(dev, word, setup);
        check("after_rst_dev",  32'(dev),  32'd1);
        check("after_rst_word", 32'(word), 32'h0080);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
